// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester round-robin arbiter in front of a single-port RAM.
// Optional power-up clear of the whole RAM is enabled by defining
// RAM_ARBITER_CLEAR_EN; without it the arbiter starts serving right after reset.
// Read results return on a shared rdata bus tagged by rvalid0/rvalid1,
// RD_LAT cycles after the grant.
module ram_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 3,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  typedef enum logic {CLEAR, RUN} state_t;

`ifdef RAM_ARBITER_CLEAR_EN
  localparam state_t RESET_STATE = CLEAR;
`else
  localparam state_t RESET_STATE = RUN;
`endif

  state_t            state, state_nx;
  logic [ADDR_W-1:0] clr_cnt;
  // fav1 = 1 means requester 0 was served last, so requester 1 wins a tie
  logic              fav1;
  logic [ADDR_W-1:0] addr_hold;
  logic [DATA_W-1:0] data_hold;
  logic [1:0]        rd_vld_p1;
  logic [1:0]        rd_vld_p2;
  logic [1:0]        rd_vld;

  // State register, clear counter, tie-break pointer and read-tracking pipeline
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= RESET_STATE;
      clr_cnt   <= '0;
      fav1      <= 1'b0;
      rd_vld_p1 <= 2'b00;
      rd_vld_p2 <= 2'b00;
    end else begin
      state <= state_nx;
      if (state == CLEAR)
        clr_cnt <= clr_cnt + ADDR_W'(1);
      if (gnt0)
        fav1 <= 1'b1;
      else if (gnt1)
        fav1 <= 1'b0;
      // stage p1: read issued to the RAM in the previous cycle
      rd_vld_p1 <= {gnt1 & ~we1, gnt0 & ~we0};
      // stage p2: extra delay for a two-cycle RAM
      rd_vld_p2 <= rd_vld_p1;
    end
  end

  // Last value driven onto the RAM address/data bus, replayed on idle cycles
  always_ff @(posedge clock) begin
    addr_hold <= ram_address;
    data_hold <= ram_data;
  end

  // Next state, grants and RAM bus mux; grants are suppressed while reset is high
  always_comb begin
    state_nx    = state;
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    ram_address = addr_hold;
    ram_data    = data_hold;
    ram_wren    = 1'b0;
    case (state)
      CLEAR: begin
        ram_wren    = 1'b1;
        ram_data    = '0;
        ram_address = clr_cnt;
        if (clr_cnt == '1)
          state_nx = RUN;
      end
      RUN: begin
        if (!reset) begin
          gnt0 = req0 & (~req1 | ~fav1);
          gnt1 = req1 & (~req0 | fav1);
        end
        if (gnt0) begin
          ram_address = addr0;
          ram_data    = wdata0;
          ram_wren    = we0;
        end else if (gnt1) begin
          ram_address = addr1;
          ram_data    = wdata1;
          ram_wren    = we1;
        end
      end
      default: state_nx = RESET_STATE;
    endcase
  end

  assign rd_vld  = (RD_LAT == 2) ? rd_vld_p2 : rd_vld_p1;
  assign rvalid0 = rd_vld[0];
  assign rvalid1 = rd_vld[1];
  assign rdata   = (|rd_vld) ? ram_q : '0;

`ifdef RAM_ARBITER_CLEAR_EN
  assign busy = (state == CLEAR);
`else
  assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: behavioural RAM, transaction-level reference
// model (shadow memory, last-served flag, queue of expected read returns).
module tb_ram_arbiter;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 3;
  localparam int RD_LAT = 1;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
  logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
  logic              gnt0, gnt1, rvalid0, rvalid1, busy, ram_wren;
  logic [DATA_W-1:0] rdata, ram_data, ram_q;
  logic [ADDR_W-1:0] ram_address;

  ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .busy(busy),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_q(ram_q)
  );

  always #5 clock = ~clock;

  // Behavioural synchronous RAM with RD_LAT-cycle read latency
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] q1, q2;
  always @(posedge clock) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    q1 <= mem[ram_address];
    q2 <= q1;
  end
  assign ram_q = (RD_LAT == 2) ? q2 : q1;

`ifdef RAM_ARBITER_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  // Reference model state
  typedef struct {
    int                due;
    bit                who;
    logic [DATA_W-1:0] val;
  } rd_t;
  rd_t               pend[$];
  logic [DATA_W-1:0] shadow [DEPTH];
  bit                last_srv;
  bit                hold_ok;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  int                cyc = 0;
  int                n_vec = 0;
  int                n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  // One arbitration cycle; called at posedge+1
  task automatic step(input bit r0, input bit w0, input logic [ADDR_W-1:0] a0,
                      input logic [DATA_W-1:0] d0, input bit r1, input bit w1,
                      input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
    bit e0, e1, ev, ew;
    logic [DATA_W-1:0] evl;
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    #3;
    e0 = r0 && (!r1 || last_srv);
    e1 = r1 && !e0;
    chk("busy", 32'(busy), 32'(0));
    chk("gnt0", 32'(gnt0), 32'(e0));
    chk("gnt1", 32'(gnt1), 32'(e1));
    chk("ram_wren", 32'(ram_wren), 32'(e0 ? w0 : (e1 ? w1 : 1'b0)));
    if (e0 || e1) begin
      m_addr = e0 ? a0 : a1;
      m_data = e0 ? d0 : d1;
      hold_ok = 1'b1;
    end
    if (hold_ok) begin
      chk("ram_address", 32'(ram_address), 32'(m_addr));
      chk("ram_data", 32'(ram_data), 32'(m_data));
    end
    ev = 1'b0; ew = 1'b0; evl = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      ev = 1'b1; ew = pend[0].who; evl = pend[0].val;
      void'(pend.pop_front());
    end
    chk("rvalid0", 32'(rvalid0), 32'(ev && !ew));
    chk("rvalid1", 32'(rvalid1), 32'(ev && ew));
    chk("rdata", 32'(rdata), 32'(evl));
    if (e0) begin
      if (w0) shadow[a0] = d0;
      else pend.push_back('{cyc + RD_LAT, 1'b0, shadow[a0]});
      last_srv = 1'b0;
    end else if (e1) begin
      if (w1) shadow[a1] = d1;
      else pend.push_back('{cyc + RD_LAT, 1'b1, shadow[a1]});
      last_srv = 1'b1;
    end
    next_cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  task automatic rnd_step();
    step(1'($urandom), 1'($urandom), ADDR_W'($urandom), DATA_W'($urandom),
         1'($urandom), 1'($urandom), ADDR_W'($urandom), DATA_W'($urandom));
  endtask

  // Assert reset mid-cycle, check forced outputs, release, then follow the clear sequence
  task automatic do_reset();
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #2;
      chk("rst_gnt0", 32'(gnt0), 32'(0));
      chk("rst_gnt1", 32'(gnt1), 32'(0));
      chk("rst_rvalid0", 32'(rvalid0), 32'(0));
      chk("rst_rvalid1", 32'(rvalid1), 32'(0));
      chk("rst_rdata", 32'(rdata), 32'(0));
      chk("rst_busy", 32'(busy), 32'(CLEAR_EN));
      if (CLEAR_EN) chk("rst_ram_address", 32'(ram_address), 32'(0));
      @(posedge clock);
      #1;
      cyc++;
    end
    reset = 1'b0;
    pend.delete();
    last_srv = 1'b1;
    req1 = 1'b0;
    if (CLEAR_EN) begin
      for (int i = 0; i < DEPTH; i++) begin
        #3;
        chk("clr_busy", 32'(busy), 32'(1));
        chk("clr_wren", 32'(ram_wren), 32'(1));
        chk("clr_address", 32'(ram_address), 32'(i));
        chk("clr_data", 32'(ram_data), 32'(0));
        chk("clr_gnt0", 32'(gnt0), 32'(0));
        chk("clr_rvalid", 32'({rvalid1, rvalid0}), 32'(0));
        next_cycle();
      end
      for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
      m_addr = ADDR_W'(DEPTH - 1);
      m_data = '0;
      hold_ok = 1'b1;
    end
  endtask

  initial begin
    hold_ok = 1'b0;
    m_addr = '0;
    m_data = '0;
    last_srv = 1'b1;
    #1;
    do_reset();
    // First access right after reset/clear: req0 still held
    step(1, 0, ADDR_W'(DEPTH - 1), '0, 0, 0, '0, '0);
    if (!CLEAR_EN) begin
      // RAM is not initialised: give every word a known value first
      for (int a = 0; a < DEPTH; a++)
        step(1, 1, ADDR_W'(a), DATA_W'($urandom), 0, 0, '0, '0);
    end
    // Top and bottom addresses
    step(0, 0, '0, '0, 1, 0, ADDR_W'(DEPTH - 1), '0);
    step(1, 1, '0, 3'd7, 0, 0, '0, '0);
    step(0, 0, '0, '0, 1, 0, '0, '0);
    idle(RD_LAT + 1);
    // Write then read back the same word from the other requester
    step(1, 1, 5'd5, 3'd6, 0, 0, '0, '0);
    step(0, 0, '0, '0, 1, 0, 5'd5, '0);
    idle(RD_LAT + 1);
    // Both requesters reading continuously: alternating grants
    for (int i = 0; i < 6; i++)
      step(1, 0, ADDR_W'($urandom), '0, 1, 0, ADDR_W'($urandom), '0);
    idle(RD_LAT + 1);
    for (int i = 0; i < 400; i++) rnd_step();
    idle(RD_LAT + 1);
    // Reset with two reads outstanding
    step(1, 0, 5'd3, '0, 1, 0, 5'd4, '0);
    step(1, 0, 5'd6, '0, 1, 0, 5'd7, '0);
    do_reset();
    idle(RD_LAT + 2);
    for (int i = 0; i < 150; i++) rnd_step();
    idle(RD_LAT + 1);
    chk("pending_drained", 32'(pend.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, RAM address width (32 words).
REQ-002 SHALL have parameter DATA_W, default 3, RAM word width.
REQ-003 SHALL have parameter RD_LAT, default 1, RAM read latency in cycles; legal values are 1 and 2.
REQ-004 SHALL have port clock  in  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports req0, req1  in  1  access request from requester 0 / 1.
REQ-007 SHALL have ports we0, we1  in  1  1 = write, 0 = read, qualified by reqN.
REQ-008 SHALL have ports addr0, addr1  in  ADDR_W  requester address.
REQ-009 SHALL have ports wdata0, wdata1  in  DATA_W  requester write data.
REQ-010 SHALL have ports gnt0, gnt1  out  1  access accepted this cycle.
REQ-011 SHALL have ports rvalid0, rvalid1  out  1  rdata holds read result for requester N.
REQ-012 SHALL have port rdata  out  DATA_W  shared read-return data.
REQ-013 SHALL have port busy  out  1  clear sequence in progress.
REQ-014 SHALL have ports ram_address  out  ADDR_W, ram_data  out  DATA_W, ram_wren  out  1, and ram_q  in  DATA_W  for connection to the RAM.

Function
REQ-015 SHALL implement states CLEAR and RUN; CLEAR advances to RUN after the cycle that writes the last address (2^ADDR_W - 1); RUN is terminal until reset.
REQ-016 In CLEAR: ram_wren=1, ram_data=0, ram_address = clear counter (0 upward, +1 per cycle), busy=1, gnt0=gnt1=0; requests are ignored, not queued.
REQ-017 In RUN: gnt0/gnt1 SHALL be combinational from req0/req1 and the priority pointer, at most one asserted per cycle; gnt is the only handshake, and a requester holding req with gnt=0 retries the following cycle.
REQ-018 With a single request, that requester SHALL be granted in the same cycle.
REQ-019 With both requesting, the requester not served last SHALL be granted; the pointer updates only on a grant; after reset the pointer favours requester 0.
REQ-020 The granted requester's addr/wdata/we SHALL drive ram_address/ram_data/ram_wren combinationally; when no grant is given, ram_wren=0 and ram_address/ram_data hold their previous values.
REQ-021 A granted read SHALL assert rvalidN for exactly one cycle, RD_LAT cycles after the grant cycle, with rdata = ram_q in that cycle; granted writes SHALL produce no rvalid.
REQ-022 Back-to-back reads SHALL be fully pipelined at one grant per cycle; rvalid0 and rvalid1 SHALL never be asserted together.
REQ-023 rdata SHALL be 0 whenever neither rvalid is asserted.

Reset
REQ-024 Assertion of reset, including mid-CLEAR or with reads in flight, SHALL immediately force: state=CLEAR, clear counter=0, pointer to favour requester 0, read-tracking pipeline flushed (rvalid0=rvalid1=0, rdata=0), gnt0=gnt1=0, busy=1.
REQ-025 Reads granted before reset SHALL never return an rvalid after reset.

Configuration
REQ-026 With macro RAM_ARBITER_CLEAR_EN defined, the CLEAR sequence SHALL run as specified after every reset.
REQ-027 Without RAM_ARBITER_CLEAR_EN, reset SHALL enter RUN directly; busy SHALL be constant 0 and RAM contents are not initialised.

Verification
REQ-028 Reset released with CLEAR_EN defined -> busy=1 and ram_wren=1 for 32 cycles with ram_address 0..31 and ram_data=0, then busy=0; a req0 held throughout receives its first gnt0 on the cycle busy drops.
REQ-029 Write addr0=5, wdata0=3'd6; next cycle read addr1=5 -> gnt0, then gnt1; rvalid1=1 with rdata=3'd6 exactly RD_LAT cycles after the gnt1 cycle.
REQ-030 req0 and req1 held high for 6 cycles, all reads -> grants alternate 0,1,0,1,0,1; rvalids follow the same order, one per cycle, RD_LAT cycles later.
REQ-031 Read of address 31 after CLEAR with no writes -> rvalid=1, rdata=0; read of address 0 after writing 3'd7 -> rdata=3'd7 (wrap-end and start addresses).
REQ-032 Reset asserted with two reads in flight -> no rvalid pulses; busy=1 and ram_address=0 while reset is high.
REQ-033 Build without RAM_ARBITER_CLEAR_EN -> busy=0 and req0 is granted in the first cycle after reset release.
